// File: rtl/adder2comp_arbiter_seq.sv
// adder2comp_arbiter_seq: round-robin sharing of one two's-complement adder datapath between two clients
module adder2comp_arbiter_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic [1:0]   req,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic [N:0]   result_in,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         loadAB,
  output logic         loadmagAB,
  output logic         compmag,
  output logic         compsigns,
  output logic         add_sub,
  output logic         loadres,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic [N:0]   result_out,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, LOAD_AB, LOAD_MAG, COMP_MAG, COMP_SIGNS, ADD_SUB, LOAD_RES, DONE} state_t;
  state_t state, nxt;
  logic last;
  logic [1:0] pick;
  // on contention the client that was not served last wins
  assign pick = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= nxt;
      if (state == IDLE && req != 2'b00) gnt <= pick;
      else if (state == DONE) begin
        gnt  <= '0;
        last <= gnt[1];
      end
    end
  always_comb begin
    nxt        = state == IDLE ? (req != 2'b00 ? LOAD_AB : IDLE) : state == DONE ? IDLE : state_t'(state + 3'd1);
    loadAB     = state == LOAD_AB;
    loadmagAB  = state == LOAD_MAG;
    compmag    = state == COMP_MAG;
    compsigns  = state == COMP_SIGNS;
    add_sub    = state == ADD_SUB;
    loadres    = state == LOAD_RES;
    busy       = state != IDLE;
    done       = state == DONE ? gnt : 2'b00;
    a          = gnt[0] ? a0 : gnt[1] ? a1 : '0;
    b          = gnt[0] ? b0 : gnt[1] ? b1 : '0;
    result_out = result_in;
  end
endmodule

// File: tb/tb_adder2comp_arbiter_seq.sv
// tb_adder2comp_arbiter_seq: directed and random checks of the arbitrated adder sequencer against a behavioural model
module tb_adder2comp_arbiter_seq;
  logic clk = 1'b0, RESET = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [4:0] result_in = '0;
  logic [3:0] a, b;
  logic loadAB, loadmagAB, compmag, compsigns, add_sub, loadres, busy;
  logic [1:0] gnt, done;
  logic [4:0] result_out;
  logic [5:0] strobes;
  logic [3:0] ra, rb;
  int passed = 0, total = 0, last_m = 1;

  adder2comp_arbiter_seq #(.N(4)) dut (
    .clk(clk), .RESET(RESET), .req(req), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .result_in(result_in), .a(a), .b(b), .loadAB(loadAB), .loadmagAB(loadmagAB),
    .compmag(compmag), .compsigns(compsigns), .add_sub(add_sub), .loadres(loadres),
    .gnt(gnt), .done(done), .result_out(result_out), .busy(busy)
  );

  always #5 clk = ~clk;
  assign strobes = {loadAB, loadmagAB, compmag, compsigns, add_sub, loadres};

  // stand-in datapath: latches operands on loadAB, registers the sign-extended sum on loadres
  always @(posedge clk) begin
    if (loadAB) begin
      ra <= a;
      rb <= b;
    end
    if (loadres) result_in <= {ra[3], ra} + {rb[3], rb};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_strobes"}, strobes, 0);
    chk({tag, "_ab"}, {a, b}, 0);
  endtask

  // one full operation; the winner drops its request at cycle drop_at (0 = keeps it)
  task automatic op(input logic [1:0] r, input int drop_at);
    int w, s;
    logic [1:0] g;
    logic [3:0] ea, eb;
    logic [4:0] er;
    req = r;
    w = (r == 2'b11) ? 1 - last_m : (r == 2'b10 ? 1 : 0);
    g = 2'(1 << w);
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    s = int'($signed(ea)) + int'($signed(eb));
    er = s[4:0];
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        chk("gnt", gnt, g);
        chk("operands", {a, b}, {ea, eb});
        chk("strobes", strobes, k <= 6 ? 32'(6'b100000 >> (k - 1)) : 0);
        chk("busy", busy, 1);
        chk("done", done, k == 7 ? g : 2'b00);
        if (k == 7) chk("result", result_out, er);
        if (k == drop_at) req[w] = 1'b0;
      end else idle_chk("bubble");
    end
    last_m = w;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1 idle_chk("reset");
    @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    idle_chk("after_reset");
    a0 = 4'b1110; b0 = 4'b1111;
    op(2'b01, 7);
    a0 = 4'd3; b0 = 4'd2; a1 = 4'b1100; b1 = 4'd1;
    op(2'b11, 7);
    op(req, 7);
    a0 = 4'd7; b0 = 4'd7; a1 = 4'b1000; b1 = 4'b1000;
    for (int i = 0; i < 4; i++) op(2'b11, 0);
    req = 2'b00;
    @(negedge clk);
    idle_chk("drained");
    req = 2'b01;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    chk("compmag_before_reset", compmag, 1);
    #2 RESET = 1'b1;
    req = 2'b00;
    #1 idle_chk("async_reset");
    last_m = 1;
    @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    idle_chk("post_reset");
    a1 = 4'b0101; b1 = 4'b1101;
    op(2'b10, 7);
    a0 = 4'b0110; b0 = 4'b1001;
    op(2'b01, 3);
    @(negedge clk);
    idle_chk("no_regrant");
    for (int i = 0; i < 8; i++) begin
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      op(2'($urandom_range(1, 3)), 7);
    end
    req = 2'b00;
    @(negedge clk);
    idle_chk("final");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
